// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: EX/MEM register, data memory, MEM/WB register,
// forwarding selects, load-use hazard detection and a retired-instruction counter.
// All state changes on the falling clock edge so it lines up with the CPU pipeline.
module mem_wb_stage #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        halt,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_store_data,
    input  logic [1:0]  ex_wr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic [1:0]  ex_rs,
    input  logic [1:0]  ex_rt,
    output logic [1:0]  wb_wr,
    output logic [15:0] wb_data,
    output logic        wb_reg_write,
    output logic [15:0] exmem_alu_out,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        load_stall,
    output logic [15:0] retired_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // EX/MEM register
    logic        exmem_valid;
    logic [15:0] exmem_store_data;
    logic [1:0]  exmem_wr;
    logic        exmem_reg_write;
    logic        exmem_mem_write;
    logic        exmem_mem_to_reg;

    // MEM/WB register
    logic        memwb_valid;
    logic [1:0]  memwb_wr;
    logic        memwb_reg_write;
    logic [15:0] memwb_data;

    // NOTE: the data memory has no reset; only its power-up contents are defined.
    logic [15:0] mem [DEPTH] = '{0: 16'd5, 1: 16'd7, default: 16'd0};

    logic [AW-1:0] word_addr;
    logic [15:0]   rd_data;
    logic          exmem_fwd_ok;

    // Word index: drop the byte bit, wrap anything beyond DEPTH words.
    assign word_addr = AW'(exmem_alu_out >> 1);
    assign rd_data   = mem[word_addr];

    // EX/MEM register: capture the EX-stage instruction unless halted.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exmem_valid      <= 1'b0;
            exmem_alu_out    <= '0;
            exmem_store_data <= '0;
            exmem_wr         <= '0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
        end else if (!halt) begin
            exmem_valid      <= ex_valid;
            exmem_alu_out    <= ex_alu_out;
            exmem_store_data <= ex_store_data;
            exmem_wr         <= ex_wr;
            exmem_reg_write  <= ex_reg_write;
            exmem_mem_write  <= ex_mem_write;
            exmem_mem_to_reg <= ex_mem_to_reg;
        end
    end

    // Data memory write for a valid store sitting in EX/MEM.
    always_ff @(negedge clock) begin
        if (reset_n && !halt && exmem_valid && exmem_mem_write) begin
            mem[word_addr] <= exmem_store_data;
        end
    end

    // MEM/WB register and retired counter: advance the EX/MEM entry unless halted.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memwb_valid     <= 1'b0;
            memwb_wr        <= '0;
            memwb_reg_write <= 1'b0;
            memwb_data      <= '0;
            retired_count   <= '0;
        end else if (!halt) begin
            memwb_valid     <= exmem_valid;
            memwb_wr        <= exmem_wr;
            memwb_reg_write <= exmem_reg_write;
            memwb_data      <= exmem_mem_to_reg ? rd_data : exmem_alu_out;
            if (exmem_valid) begin
                retired_count <= retired_count + 16'd1;
            end
        end
    end

    assign wb_wr        = memwb_wr;
    assign wb_data      = memwb_data;
    assign wb_reg_write = memwb_valid && memwb_reg_write && (memwb_wr != 2'd0);

    // A load result is not ready in EX/MEM, so only ALU results forward from there.
    assign exmem_fwd_ok = exmem_valid && exmem_reg_write && !exmem_mem_to_reg
                          && (exmem_wr != 2'd0);

    // Forwarding selects: EX/MEM beats MEM/WB, otherwise use the register file.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (exmem_fwd_ok && (exmem_wr == ex_rs)) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write && (memwb_wr == ex_rs)) begin
            fwd_a = 2'b01;
        end
        if (exmem_fwd_ok && (exmem_wr == ex_rt)) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write && (memwb_wr == ex_rt)) begin
            fwd_b = 2'b01;
        end
    end

    // Load-use hazard: a load in EX/MEM targets a source of the EX instruction.
    assign load_stall = exmem_valid && exmem_mem_to_reg && (exmem_wr != 2'd0)
                        && ((exmem_wr == ex_rs) || (exmem_wr == ex_rt));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a
// transaction-level model of the two-slot pipeline and the data memory.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;

    logic        clock;
    logic        reset_n;
    logic        halt;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_store_data;
    logic [1:0]  ex_wr;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic [1:0]  ex_rs;
    logic [1:0]  ex_rt;
    logic [1:0]  wb_wr;
    logic [15:0] wb_data;
    logic        wb_reg_write;
    logic [15:0] exmem_alu_out;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        load_stall;
    logic [15:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    mem_wb_stage #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .halt          (halt),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_wr         (ex_wr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .wb_wr         (wb_wr),
        .wb_data       (wb_data),
        .wb_reg_write  (wb_reg_write),
        .exmem_alu_out (exmem_alu_out),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .load_stall    (load_stall),
        .retired_count (retired_count)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [15:0] alu;
        logic [15:0] st;
        logic [1:0]  wr;
        bit          rw;
        bit          mw;
        bit          m2r;
    } instr_t;

    typedef struct {
        bit          v;
        logic [1:0]  wr;
        bit          rw;
        logic [15:0] data;
    } wb_t;

    instr_t      m_in_mem;     // instruction currently in the memory stage
    wb_t         m_wb;         // result presented to writeback
    logic [15:0] m_retired;
    logic [15:0] m_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'd0;
        m_mem[0] = 16'd5;
        m_mem[1] = 16'd7;
        m_in_mem  = '{default: 0};
        m_wb      = '{default: 0};
        m_retired = 16'd0;
    end

    // One pipeline step: the memory-stage instruction finishes (read, then
    // its own store), the EX instruction moves into the memory stage.
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_in_mem  = '{default: 0};
            m_wb      = '{default: 0};
            m_retired = 16'd0;
        end else if (!halt) begin
            int addr;
            addr = (int'(m_in_mem.alu) / 2) % DEPTH;
            m_wb.v    = m_in_mem.v;
            m_wb.wr   = m_in_mem.wr;
            m_wb.rw   = m_in_mem.rw;
            m_wb.data = m_in_mem.m2r ? m_mem[addr] : m_in_mem.alu;
            if (m_in_mem.v) m_retired = m_retired + 16'd1;
            if (m_in_mem.v && m_in_mem.mw) m_mem[addr] = m_in_mem.st;
            m_in_mem = '{v: ex_valid, alu: ex_alu_out, st: ex_store_data, wr: ex_wr,
                         rw: ex_reg_write, mw: ex_mem_write, m2r: ex_mem_to_reg};
        end
    end

    function automatic logic [1:0] exp_fwd(input logic [1:0] src, input bit wb_we);
        if (m_in_mem.v && m_in_mem.rw && !m_in_mem.m2r && m_in_mem.wr != 0 && m_in_mem.wr == src)
            return 2'b10;
        if (wb_we && m_wb.wr == src)
            return 2'b01;
        return 2'b00;
    endfunction

    // Compare every DUT output to the model on the non-active (rising) edge.
    always @(posedge clock) begin
        if (cmp_en) begin
            bit wb_we;
            bit stall;
            wb_we = m_wb.v && m_wb.rw && (m_wb.wr != 0);
            stall = m_in_mem.v && m_in_mem.m2r && (m_in_mem.wr != 0)
                    && (m_in_mem.wr == ex_rs || m_in_mem.wr == ex_rt);
            check("m_wb_wr",        16'(wb_wr),        16'(m_wb.wr));
            check("m_wb_data",      wb_data,           m_wb.data);
            check("m_wb_reg_write", 16'(wb_reg_write), 16'(wb_we));
            check("m_exmem_alu",    exmem_alu_out,     m_in_mem.alu);
            check("m_fwd_a",        16'(fwd_a),        16'(exp_fwd(ex_rs, wb_we)));
            check("m_fwd_b",        16'(fwd_b),        16'(exp_fwd(ex_rt, wb_we)));
            check("m_load_stall",   16'(load_stall),   16'(stall));
            check("m_retired",      retired_count,     m_retired);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ex(input bit v, input logic [15:0] alu, input logic [15:0] st,
                          input logic [1:0] wr, input bit rw, input bit mw, input bit m2r,
                          input logic [1:0] rs, input logic [1:0] rt);
        ex_valid      = v;
        ex_alu_out    = alu;
        ex_store_data = st;
        ex_wr         = wr;
        ex_reg_write  = rw;
        ex_mem_write  = mw;
        ex_mem_to_reg = m2r;
        ex_rs         = rs;
        ex_rt         = rt;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic bubble(input logic [1:0] rs, input logic [1:0] rt);
        set_ex(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, rs, rt);
    endtask

    initial begin
        reset_n = 1'b0;
        halt    = 1'b0;
        bubble(2'd0, 2'd0);
        tick();
        cmp_en = 1;
        tick();
        // Reset state
        check("rst_retired", retired_count, 16'h0000);
        check("rst_wb_we",   16'(wb_reg_write), 16'h0000);
        check("rst_fwd_a",   16'(fwd_a), 16'h0000);
        check("rst_fwd_b",   16'(fwd_b), 16'h0000);
        check("rst_stall",   16'(load_stall), 16'h0000);
        check("rst_wb_data", wb_data, 16'h0000);
        reset_n = 1'b1;

        // ALU pass-through
        set_ex(1, 16'h000F, 16'h0000, 2'd1, 1, 0, 0, 2'd0, 2'd0);
        tick();
        bubble(2'd0, 2'd0);
        tick();
        check("alu_wb_data", wb_data, 16'h000F);
        check("alu_wb_wr",   16'(wb_wr), 16'h0001);
        check("alu_wb_we",   16'(wb_reg_write), 16'h0001);
        check("alu_retired", retired_count, 16'h0001);

        // Load from initial memory, load-use stall via rs then via rt
        set_ex(1, 16'h0002, 16'h0000, 2'd2, 1, 0, 1, 2'd0, 2'd0);
        tick();
        bubble(2'd2, 2'd0);
        #1;
        check("lw_stall_rs", 16'(load_stall), 16'h0001);
        check("lw_no_fwd",   16'(fwd_a), 16'h0000);
        bubble(2'd1, 2'd2);
        #1;
        check("lw_stall_rt", 16'(load_stall), 16'h0001);
        tick();
        check("lw_wb_data",  wb_data, 16'h0007);
        check("lw_wb_wr",    16'(wb_wr), 16'h0002);
        check("lw_stall_off", 16'(load_stall), 16'h0000);

        // Store then load to the same word on the next cycle
        set_ex(1, 16'h0010, 16'hBEEF, 2'd0, 0, 1, 0, 2'd0, 2'd0);
        tick();
        set_ex(1, 16'h0011, 16'h0000, 2'd1, 1, 0, 1, 2'd0, 2'd0);
        tick();
        bubble(2'd0, 2'd0);
        tick();
        check("sw_lw_data", wb_data, 16'hBEEF);

        // Forwarding priority
        set_ex(1, 16'h1111, 16'h0000, 2'd3, 1, 0, 0, 2'd0, 2'd0);
        tick();
        set_ex(1, 16'h2222, 16'h0000, 2'd3, 1, 0, 0, 2'd0, 2'd0);
        tick();
        bubble(2'd3, 2'd3);
        #1;
        check("fwd_a_exmem", 16'(fwd_a), 16'h0002);
        check("fwd_b_exmem", 16'(fwd_b), 16'h0002);
        check("fwd_exmem_alu", exmem_alu_out, 16'h2222);
        tick();
        check("fwd_a_memwb", 16'(fwd_a), 16'h0001);
        check("fwd_memwb_data", wb_data, 16'h2222);

        // Register 0 is never written or forwarded
        set_ex(1, 16'h0055, 16'h0000, 2'd0, 1, 0, 0, 2'd0, 2'd0);
        tick();
        bubble(2'd0, 2'd0);
        #1;
        check("r0_fwd_a_exmem", 16'(fwd_a), 16'h0000);
        tick();
        check("r0_wb_we",   16'(wb_reg_write), 16'h0000);
        check("r0_fwd_a",   16'(fwd_a), 16'h0000);
        check("r0_fwd_b",   16'(fwd_b), 16'h0000);
        check("r0_wb_data", wb_data, 16'h0055);

        // Halt: three edges frozen, the input offered during halt is dropped
        set_ex(1, 16'h0077, 16'h0000, 2'd2, 1, 0, 0, 2'd0, 2'd0);
        tick();
        halt = 1'b1;
        set_ex(1, 16'h0099, 16'h0000, 2'd1, 1, 0, 0, 2'd2, 2'd0);
        tick();
        tick();
        tick();
        check("halt_exmem_alu", exmem_alu_out, 16'h0077);
        check("halt_wb_data",   wb_data, 16'h0000);
        check("halt_retired",   retired_count, 16'h0007);
        check("halt_fwd_a",     16'(fwd_a), 16'h0002);
        halt = 1'b0;
        bubble(2'd0, 2'd0);
        tick();
        check("unhalt_wb_data", wb_data, 16'h0077);
        check("unhalt_wb_we",   16'(wb_reg_write), 16'h0001);
        check("unhalt_retired", retired_count, 16'h0008);
        tick();
        check("dropped_alu",    exmem_alu_out, 16'h0000);
        check("dropped_wb_we",  16'(wb_reg_write), 16'h0000);
        check("dropped_retired", retired_count, 16'h0008);

        // Reset with a store in EX/MEM: the store must never land
        set_ex(1, 16'h0000, 16'hDEAD, 2'd0, 0, 1, 0, 2'd0, 2'd0);
        tick();
        bubble(2'd0, 2'd0);
        #2 reset_n = 1'b0;
        tick();
        check("rst_mid_retired", retired_count, 16'h0000);
        check("rst_mid_wb_we",   16'(wb_reg_write), 16'h0000);
        reset_n = 1'b1;
        set_ex(1, 16'h0000, 16'h0000, 2'd1, 1, 0, 1, 2'd0, 2'd0);
        tick();
        bubble(2'd0, 2'd0);
        tick();
        check("rst_mem_kept", wb_data, 16'h0005);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [15:0] addr;
            case ($urandom_range(0, 3))
                0: addr = 16'($urandom);
                1: addr = 16'($urandom_range(0, 15));
                2: addr = 16'h0200 + 16'($urandom_range(0, 15));
                default: addr = 16'hFFF0 + 16'($urandom_range(0, 15));
            endcase
            set_ex($urandom_range(0, 3) != 0, addr, 16'($urandom), 2'($urandom),
                   1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   2'($urandom), 2'($urandom));
            halt = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        halt = 1'b0;
        bubble(2'd0, 2'd0);
        tick();
        tick();
        cmp_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 16-bit data-memory words; it SHALL be a power of two.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its falling edge, matching the CPU pipeline.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port halt, input, 1 bit: when high, all registers, counters and memory hold.
REQ-005 The block SHALL have these EX-stage inputs:
- ex_valid, input, 1 bit
- ex_alu_out, input, 16 bits
- ex_store_data, input, 16 bits
- ex_wr, input, 2 bits
- ex_reg_write, input, 1 bit
- ex_mem_write, input, 1 bit
- ex_mem_to_reg, input, 1 bit
REQ-006 The block SHALL have ports ex_rs and ex_rt, input, 2 bits each: source registers of the instruction currently in EX.
REQ-007 The block SHALL have these writeback outputs, all driven from the MEM/WB register:
- wb_wr, output, 2 bits
- wb_data, output, 16 bits
- wb_reg_write, output, 1 bit
REQ-008 The block SHALL have port exmem_alu_out, output, 16 bits: the EX/MEM ALU result, used as forwarding data.
REQ-009 The block SHALL have ports fwd_a and fwd_b, output, 2 bits each: forwarding selects for the A and B operands.
REQ-010 The block SHALL have port load_stall, output, 1 bit: load-use hazard indication.
REQ-011 The block SHALL have port retired_count, output, 16 bits: count of retired valid instructions.

Function
REQ-012 At each falling clock edge with halt low, the EX/MEM register SHALL capture all ex_* inputs.
REQ-013 Memory SHALL be addressed by word index (exmem_alu_out >> 1) mod DEPTH; address bit 0 SHALL be ignored and higher addresses SHALL wrap.
REQ-014 The memory write SHALL occur at the falling edge following EX/MEM capture when EX/MEM valid and mem_write are both high.
REQ-015 The memory read SHALL be combinational from the EX/MEM address.
REQ-016 At the same falling edge as REQ-014, the MEM/WB register SHALL capture valid, wr, reg_write, and data, where data is read data if mem_to_reg is set and the ALU result otherwise.
REQ-017 wb_reg_write SHALL equal MEM/WB valid AND reg_write AND (wb_wr != 0); writes to register 0 are never requested.
REQ-018 Latency SHALL be as follows:
- EX inputs sampled at falling edge n.
- wb_* outputs valid after falling edge n+1.
- The register file commits at falling edge n+2.
REQ-019 A store followed by a load to the same word on the next cycle SHALL return the new data (the write at edge n+1 precedes the read at edge n+2).
REQ-020 fwd_a SHALL be 2'b10 when EX/MEM valid, reg_write set, mem_to_reg clear, wr != 0 and wr == ex_rs.
REQ-021 Otherwise fwd_a SHALL be 2'b01 when wb_reg_write is high and wb_wr == ex_rs.
REQ-022 Otherwise fwd_a SHALL be 2'b00.
REQ-023 fwd_b SHALL follow REQ-020 to REQ-022 with ex_rt in place of ex_rs; EX/MEM priority SHALL take precedence over MEM/WB.
REQ-024 load_stall SHALL be high when EX/MEM valid, mem_to_reg set, wr != 0, and wr equals ex_rs or ex_rt.
REQ-025 retired_count SHALL increment by 1 on each MEM/WB capture of a valid entry, wrapping from 0xFFFF to 0x0000.
REQ-026 With halt high, captures, the memory write and the counter increment SHALL be suppressed; combinational outputs SHALL continue to track the held state.
REQ-027 A simultaneous valid input and halt high SHALL result in the input being dropped, not queued.

Reset
REQ-028 While reset_n is low, the block SHALL clear EX/MEM and MEM/WB valid, reg_write, mem_write and mem_to_reg, and force wr and data to 0.
REQ-029 Reset SHALL clear retired_count to 0 and drive fwd_a = fwd_b = 2'b00, load_stall = 0 and wb_reg_write = 0.
REQ-030 Data-memory contents SHALL NOT be cleared by reset; word 0 SHALL initialise to 5 and word 1 to 7.
REQ-031 Reset asserted mid-operation SHALL discard in-flight entries, and no pending memory write SHALL occur after reset assertion.
REQ-032 Deassertion SHALL take effect from the next falling edge.

Verification
REQ-033 ALU pass-through: addi result 0x000F with wr=1 and reg_write=1 -> after the second falling edge, wb_data=0x000F, wb_wr=1, wb_reg_write=1 and retired_count=1.
REQ-034 Load from initial memory: lw with address 0x0002 and wr=2 -> wb_data=7; next-cycle ex_rs=2 gives load_stall=1 while lw is in EX/MEM.
REQ-035 Store then load: sw of 0xBEEF to address 0x0010, then lw from 0x0011 on the next cycle -> wb_data=0xBEEF (bit 0 ignored).
REQ-036 Forwarding priority: add wr=3, then sub wr=3, then ex_rs=3 -> fwd_a=2'b10 while sub is in EX/MEM and add is in MEM/WB; with the EX/MEM entry invalid, fwd_a=2'b01.
REQ-037 Register 0: an entry with wr=0 and reg_write=1 -> wb_reg_write=0 and fwd_a=fwd_b=0.
REQ-038 Halt and reset: halt high for 3 edges -> outputs frozen; reset_n pulsed low while a store is in EX/MEM -> memory unchanged, retired_count=0, wb_reg_write=0.
